// File: rtl/twiddle_mult_stage.sv
// Purpose: streaming complex twiddle multiplier that picks coefficient k for sample k of each frame.
// Latency: 3 cycles from input transfer to out_valid; 1 sample/cycle throughput.
// Backpressure: one global advance enable; in_ready = !out_valid || out_ready, so a stalled output freezes every stage.
//
// Optional feature macro: TWIDDLE_SAT_EN
//   defined   -> rounded products saturate to the signed NBITS range
//   undefined -> rounded products wrap (keep low NBITS bits)
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   coeff_data          packed coefficient ROM bus, index 0 in the MSB field,
//                       each field = {re[NBITS-1:0], im[NBITS-1:0]}
//   in_valid/in_ready   input handshake, in_re/in_im signed sample
//   out_valid/out_ready output handshake, out_re/out_im signed product,
//                       out_last marks the product for frame index N-1
module twiddle_mult_stage #(
  parameter int NBITS = 5,
  parameter int N     = 8,
  parameter int CFRAC = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NBITS*N*2-1:0]   coeff_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NBITS-1:0]       in_re,
  input  logic [NBITS-1:0]       in_im,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NBITS-1:0]       out_re,
  output logic [NBITS-1:0]       out_im,
  output logic                   out_last
);

  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam int PW   = 2 * NBITS;   // product width
  localparam int SW   = PW + 1;      // sum/difference width
  localparam int RW   = SW + 1;      // headroom so the rounding add can never wrap

  localparam logic [IDXW-1:0]      IDX_LAST = IDXW'(N - 1);
  localparam logic signed [RW-1:0] RND_HALF = RW'(2 ** (CFRAC - 1));

`ifdef TWIDDLE_SAT_EN
  localparam logic signed [RW-1:0] SAT_MAX = RW'((2 ** (NBITS - 1)) - 1);
  localparam logic signed [RW-1:0] SAT_MIN = -SAT_MAX - RW'(1);
`endif

  // Narrow a rounded, shifted value to the output field width.
  function automatic logic [NBITS-1:0] reduce(input logic signed [RW-1:0] v);
`ifdef TWIDDLE_SAT_EN
    if (v > SAT_MAX) begin
      return NBITS'(SAT_MAX);
    end else if (v < SAT_MIN) begin
      return NBITS'(SAT_MIN);
    end else begin
      return NBITS'(v);
    end
`else
    return NBITS'(v);
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // Coefficient unpack: field k sits at [2*NBITS*(N-k)-1 : 2*NBITS*(N-1-k)]
  // ---------------------------------------------------------------------------
  logic [NBITS-1:0] coef_re_arr [N];
  logic [NBITS-1:0] coef_im_arr [N];

  for (genvar k = 0; k < N; k++) begin : g_coef
    assign coef_re_arr[k] = coeff_data[2*NBITS*(N-k)-1 -: NBITS];
    assign coef_im_arr[k] = coeff_data[2*NBITS*(N-1-k) +: NBITS];
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [IDXW-1:0]        idx_q,      idx_d;

  logic                   v1_q,       v1_d;
  logic [NBITS-1:0]       s1_are_q,   s1_are_d;
  logic [NBITS-1:0]       s1_aim_q,   s1_aim_d;
  logic [NBITS-1:0]       s1_cre_q,   s1_cre_d;
  logic [NBITS-1:0]       s1_cim_q,   s1_cim_d;
  logic                   s1_last_q,  s1_last_d;

  logic                   v2_q,       v2_d;
  logic signed [PW-1:0]   p_rr_q,     p_rr_d;
  logic signed [PW-1:0]   p_ii_q,     p_ii_d;
  logic signed [PW-1:0]   p_ri_q,     p_ri_d;
  logic signed [PW-1:0]   p_ir_q,     p_ir_d;
  logic                   s2_last_q,  s2_last_d;

  logic                   out_valid_q, out_valid_d;
  logic [NBITS-1:0]       out_re_q,    out_re_d;
  logic [NBITS-1:0]       out_im_q,    out_im_d;
  logic                   out_last_q,  out_last_d;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic adv;
  logic in_xfer;

  assign adv     = !out_valid_q || out_ready;
  assign in_xfer = in_valid && adv;

  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign out_last  = out_last_q;

  // ---------------------------------------------------------------------------
  // Stage 3 arithmetic: complex sum, round half up, arithmetic shift
  // ---------------------------------------------------------------------------
  logic signed [SW-1:0] re_sum, im_sum;
  logic signed [RW-1:0] re_rnd, im_rnd;
  logic signed [RW-1:0] re_shr, im_shr;

  always_comb begin
    re_sum = SW'(p_rr_q) - SW'(p_ii_q);
    im_sum = SW'(p_ri_q) + SW'(p_ir_q);
    re_rnd = RW'(re_sum) + RND_HALF;
    im_rnd = RW'(im_sum) + RND_HALF;
    re_shr = re_rnd >>> CFRAC;
    im_shr = im_rnd >>> CFRAC;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Data registers only load behind a valid slot so a
  // bubble never disturbs the value sitting on the output.
  // ---------------------------------------------------------------------------
  always_comb begin
    idx_d       = idx_q;
    v1_d        = v1_q;
    s1_are_d    = s1_are_q;
    s1_aim_d    = s1_aim_q;
    s1_cre_d    = s1_cre_q;
    s1_cim_d    = s1_cim_q;
    s1_last_d   = s1_last_q;
    v2_d        = v2_q;
    p_rr_d      = p_rr_q;
    p_ii_d      = p_ii_q;
    p_ri_d      = p_ri_q;
    p_ir_d      = p_ir_q;
    s2_last_d   = s2_last_q;
    out_valid_d = out_valid_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    out_last_d  = out_last_q;

    // Frame index only moves on an accepted sample.
    if (in_xfer) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDXW'(1);
    end

    if (adv) begin
      // Stage 1: capture sample and its coefficient
      v1_d = in_valid;
      if (in_valid) begin
        s1_are_d  = in_re;
        s1_aim_d  = in_im;
        s1_cre_d  = coef_re_arr[idx_q];
        s1_cim_d  = coef_im_arr[idx_q];
        s1_last_d = (idx_q == IDX_LAST);
      end

      // Stage 2: four partial products
      v2_d = v1_q;
      if (v1_q) begin
        p_rr_d    = PW'($signed(s1_are_q)) * PW'($signed(s1_cre_q));
        p_ii_d    = PW'($signed(s1_aim_q)) * PW'($signed(s1_cim_q));
        p_ri_d    = PW'($signed(s1_are_q)) * PW'($signed(s1_cim_q));
        p_ir_d    = PW'($signed(s1_aim_q)) * PW'($signed(s1_cre_q));
        s2_last_d = s1_last_q;
      end

      // Stage 3: rounded, width-reduced result
      out_valid_d = v2_q;
      if (v2_q) begin
        out_re_d   = reduce(re_shr);
        out_im_d   = reduce(im_shr);
        out_last_d = s2_last_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q       <= '0;
      v1_q        <= 1'b0;
      s1_are_q    <= '0;
      s1_aim_q    <= '0;
      s1_cre_q    <= '0;
      s1_cim_q    <= '0;
      s1_last_q   <= 1'b0;
      v2_q        <= 1'b0;
      p_rr_q      <= '0;
      p_ii_q      <= '0;
      p_ri_q      <= '0;
      p_ir_q      <= '0;
      s2_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_last_q  <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      v1_q        <= v1_d;
      s1_are_q    <= s1_are_d;
      s1_aim_q    <= s1_aim_d;
      s1_cre_q    <= s1_cre_d;
      s1_cim_q    <= s1_cim_d;
      s1_last_q   <= s1_last_d;
      v2_q        <= v2_d;
      p_rr_q      <= p_rr_d;
      p_ii_q      <= p_ii_d;
      p_ri_q      <= p_ri_d;
      p_ir_q      <= p_ir_d;
      s2_last_q   <= s2_last_d;
      out_valid_q <= out_valid_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule

// File: tb/tb_twiddle_mult_stage.sv
// Purpose: directed self-checking bench for twiddle_mult_stage with hand-computed products.
// Latency: checks the 3-cycle input-to-output latency and full-rate streaming.
// Backpressure: exercises out_ready stalls, input bubbles and mid-frame reset.
module tb_twiddle_mult_stage;

  localparam int NBITS = 5;
  localparam int N     = 8;
  localparam int CFRAC = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NBITS*N*2-1:0] coeff_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [NBITS-1:0]     in_re;
  logic [NBITS-1:0]     in_im;
  logic                 out_valid;
  logic                 out_ready;
  logic [NBITS-1:0]     out_re;
  logic [NBITS-1:0]     out_im;
  logic                 out_last;

  twiddle_mult_stage #(.NBITS(NBITS), .N(N), .CFRAC(CFRAC)) dut (
    .clk        (clk),
    .rst        (rst),
    .coeff_data (coeff_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_re      (in_re),
    .in_im      (in_im),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_re     (out_re),
    .out_im     (out_im),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int re;
    int im;
    int last;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   first_out_cyc = -1;

  // Coefficient fields 0..7, index 0 lands in the MSB field.
  int coef_re_tab[N] = '{4, -3, 4,  0, 4, -3, 4,  0};
  int coef_im_tab[N] = '{0, -3, 0, -4, 0, -3, 0, -4};

  task automatic check(input string tag, input int obs, input int expv);
    n_chk++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic push_exp(input int re, input int im, input int last);
    exp_t e;
    e.re = re;
    e.im = im;
    e.last = last;
    exp_q.push_back(e);
  endtask

  // One clock: drive inputs at the falling edge, let in_ready settle, and
  // score the output if it is going to transfer on the next rising edge.
  task automatic tick(input logic v, input int re, input int im, input logic ordy,
                      output logic acc);
    exp_t e;
    @(negedge clk);
    cyc++;
    in_valid  = v;
    in_re     = re[NBITS-1:0];
    in_im     = im[NBITS-1:0];
    out_ready = ordy;
    #1;
    acc = v && in_ready;
    if (acc) acc_cyc = cyc;
    if (out_valid && out_ready) begin
      if (first_out_cyc < 0) first_out_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_out", int'(out_valid), 0);
      end else begin
        e = exp_q.pop_front();
        check("out_re",   int'($signed(out_re)), e.re);
        check("out_im",   int'($signed(out_im)), e.im);
        check("out_last", int'(out_last),        e.last);
      end
    end
  endtask

  task automatic send(input int re, input int im);
    logic a;
    int   guard;
    a = 1'b0;
    guard = 0;
    while (!a && guard < 50) begin
      tick(1'b1, re, im, 1'b1, a);
      guard++;
    end
    if (!a) check("send_timeout", guard, -1);
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) tick(1'b0, 0, 0, 1'b1, a);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 30) begin
      idle(1);
      guard++;
    end
    check("drain_left", exp_q.size(), 0);
    idle(3);
  endtask

  // Bubble table starting at index 0: sample, expected product, last, bubble after.
  int t3_in_re [10] = '{4, 4, 4, 4, 4, 4, 4, 4, 4,   -16};
  int t3_in_im [10] = '{0, 0, 0, 4, 0, 0, 0, 0, 0,   -16};
  int t3_ex_re [10] = '{4, -3, 4, 4, 4, -3, 4, 0, 4, 0};
  int t3_ex_im [10] = '{0, -3, 0, -4, 0, -3, 0, -4, 0, 0};
  int t3_last  [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
  int t3_bub   [10] = '{1, 0, 2, 0, 0, 1, 0, 0, 1, 0};

  // Stall stream starting at index 2.
  int t4_in_re [8] = '{1, 2, 3, 4, 5, 6, 7, -4};
  int t4_ex_re [8] = '{1, 0, 3, -3, 5, 0, 7, 3};
  int t4_ex_im [8] = '{0, -2, 0, -3, 0, -6, 0, 3};
  int t4_last  [8] = '{0, 0, 0, 0, 0, 1, 0, 0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    logic a;
    int   c0;
    int   sat_im;

    for (int k = 0; k < N; k++) begin
      coeff_data[2*NBITS*(N-k)-1 -: NBITS] = coef_re_tab[k][NBITS-1:0];
      coeff_data[2*NBITS*(N-1-k) +: NBITS] = coef_im_tab[k][NBITS-1:0];
    end
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_re     = '0;
    in_im     = '0;
    out_ready = 1'b1;
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready",  int'(in_ready),  1);
    check("rst_out_re",    int'(out_re),    0);
    check("rst_out_im",    int'(out_im),    0);
    check("rst_out_last",  int'(out_last),  0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Eight back-to-back (4,0) samples.
    for (int k = 0; k < N; k++) begin
      case (k % 4)
        0, 2: push_exp(4, 0, 0);
        1:    push_exp(-3, -3, 0);
        default: push_exp(0, -4, (k == N - 1) ? 1 : 0);
      endcase
    end
    first_out_cyc = -1;
    send(4, 0);
    c0 = acc_cyc;
    for (int k = 1; k < N; k++) send(4, 0);
    drain();
    check("latency", first_out_cyc - c0, 3);

    // Bubbles, (4,4) at index 3, (-16,-16) at index 1.
`ifdef TWIDDLE_SAT_EN
    sat_im = 15;
`else
    sat_im = -8;
`endif
    for (int i = 0; i < 10; i++) begin
      push_exp(t3_ex_re[i], (i == 9) ? sat_im : t3_ex_im[i], t3_last[i]);
      send(t3_in_re[i], t3_in_im[i]);
      for (int b = 0; b < t3_bub[i]; b++) tick(1'b0, 0, 0, 1'b1, a);
    end
    drain();

    // Full-rate stream with a 5-cycle output stall after three samples.
    for (int i = 0; i < 8; i++) push_exp(t4_ex_re[i], t4_ex_im[i], t4_last[i]);
    for (int i = 0; i < 3; i++) send(t4_in_re[i], 0);
    for (int s = 0; s < 5; s++) begin
      tick(1'b1, t4_in_re[3], 0, 1'b0, a);
      check("stall_in_ready",  int'(in_ready),          0);
      check("stall_out_valid", int'(out_valid),         1);
      check("stall_out_re",    int'($signed(out_re)),   1);
      check("stall_out_im",    int'($signed(out_im)),   0);
    end
    for (int i = 3; i < 8; i++) send(t4_in_re[i], 0);
    drain();

    // Reset after three accepted samples (indices 2,3,4).
    for (int i = 0; i < 3; i++) send(4, 0);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_out_re",    int'(out_re),    0);
    check("mid_rst_out_last",  int'(out_last),  0);
    check("mid_rst_in_ready",  int'(in_ready),  1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      check("post_rst_out_valid", int'(out_valid), 0);
    end
    push_exp(4, 0, 0);
    push_exp(-3, -3, 0);
    send(4, 0);
    send(4, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/twiddle_mult_stage.md
# twiddle_mult_stage

Streaming complex twiddle multiplier that sits directly downstream of the packed coefficient ROM. It consumes that ROM's flat `coeff_data` bus together with one complex sample per cycle. It selects coefficient k for the k-th sample of each N-sample frame and outputs the rounded, width-reduced complex product through a 3-stage pipeline with valid/ready backpressure. The output feeds the next butterfly stage of the FFT.

## Interface
- `NBITS`, 5: width of each real/imag field, for data and coefficient alike (signed two's complement).
- `N`, 8: coefficients per frame, equal to the samples per frame.
- `CFRAC`, 2: fractional bits of the coefficient format, so 1.0 = 2^CFRAC. Valid range is 1..NBITS-2.

Ports:
- `clk`, input, 1: single clock; all state is on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `coeff_data`, input, NBITS*N*2: packed coefficients.
  - Coefficient k occupies bits [2*NBITS*(N-k)-1 : 2*NBITS*(N-1-k)], so index 0 is in the MSB field.
  - Within each field, the real part is the upper NBITS and the imaginary part is the lower NBITS.
- `in_valid`, input, 1: input sample present.
- `in_ready`, output, 1: the stage accepts the input this cycle.
- `in_re`, `in_im`, input, NBITS each: signed input sample.
- `out_valid`, output, 1: output sample present.
- `out_ready`, input, 1: the downstream consumer accepts the output.
- `out_re`, `out_im`, output, NBITS each: signed product.
- `out_last`, output, 1: high with the product for frame index N-1.

## Operation
- Handshakes:
  - An input transfer occurs when `in_valid && in_ready`.
  - An output transfer occurs when `out_valid && out_ready`.
- Global advance enable: `adv = !out_valid || out_ready`.
  - `in_ready = adv`.
  - Every pipeline register, including the valid bits, loads only when `adv` is high.
- Index counter `idx`, width clog2(N):
  - Increments on each input transfer.
  - Wraps from N-1 to 0.
  - Holds when no transfer occurs.
- Stage 1 (on input transfer):
  - Registers `in_re`, `in_im`, coefficient `idx` (cr, ci) and the flag `last = (idx == N-1)`.
  - v1 <= `in_valid`.
- Stage 2: registers the four signed products ar*cr, ai*ci, ar*ci and ai*cr, each 2*NBITS bits wide. v2 <= v1.
- Stage 3:
  - Sums: re = ar*cr - ai*ci and im = ar*ci + ai*cr, each 2*NBITS+1 bits.
  - Rounding: add 2^(CFRAC-1), then arithmetic-shift right by CFRAC (round half up).
  - Reduces the result to NBITS per the Configuration section and registers it to `out_re`, `out_im`, `out_last`.
  - `out_valid` <= v2.
- Bubbles (`in_valid` low while `adv` is high) propagate as invalid slots and do not advance `idx`.
- Each output sample carries the index it was tagged with at input. `coeff_data` is treated as static during operation.

## Timing
- Latency: 3 cycles from input transfer to `out_valid` when there is no backpressure.
- Throughput: 1 sample per cycle.
- Stall: while `out_valid && !out_ready`, all stages and `idx` hold, and `in_ready` = 0 in the same cycle (combinational from `out_ready`).
- Simultaneous input and output transfer in one cycle is the normal full-rate case; nothing is lost or duplicated.
- Reset values:
  - `out_valid`, `out_last`, `out_re`, `out_im`, v1, v2 and `idx` are all 0.
  - `in_ready` = 1.
- Reset asserted mid-frame discards all in-flight samples. The next accepted sample uses coefficient 0.

## Configuration
- `TWIDDLE_SAT_EN` defined: the rounded result saturates to [-2^(NBITS-1), 2^(NBITS-1)-1].
- `TWIDDLE_SAT_EN` undefined: the rounded result is truncated to its low NBITS bits (two's-complement wrap).

## Test plan
All scenarios use the defaults, with coeff fields 0 to 7 = (4,0), (-3,-3), (4,0), (0,-4), (4,0), (-3,-3), (4,0), (0,-4).
- Eight back-to-back samples of (4,0), `out_ready` = 1:
  - Outputs appear starting 3 cycles after the first input: (4,0), (-3,-3), (4,0), (0,-4), repeated.
  - `out_last` is high only on the 8th output.
- Sample (4,4) at index 3 -> output (4,-4).
- Sample (-16,-16) at index 1:
  - With `TWIDDLE_SAT_EN`: output (0,15).
  - Without `TWIDDLE_SAT_EN`: output (0,-8).
- Hold `out_ready` = 0 for 5 cycles during a full-rate stream:
  - `in_ready` drops in the same cycle.
  - The output holds its value.
  - No sample is lost or duplicated, and the index sequence stays intact.
- Interleave `in_valid` bubbles -> output values are unchanged, and coefficient indices advance only on input transfers.
- Assert `rst` after 3 accepted samples:
  - All outputs and valid bits are 0 and `in_ready` = 1.
  - The next sample, (4,0), produces (4,0) using coefficient 0.
